// File: rtl/led_pkg.sv
// Shared types and defaults for the LED breathing stage.
package led_pkg;

  localparam int DEF_PWM_BITS   = 8;
  localparam int DEF_HOLD_STEPS = 16;

  typedef enum logic [1:0] {
    UP      = 2'd0,
    HOLD_HI = 2'd1,
    DOWN    = 2'd2,
    HOLD_LO = 2'd3
  } phase_t;

  // A hold of a single step still needs a one-bit counter.
  function automatic int hold_cnt_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/led_pwm_core.sv
// Free-running PWM counter with registered compare output and period-wrap flag.
module led_pwm_core #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_out,
  output logic                wrap
);

  localparam logic [PWM_BITS-1:0] CNT_MAX = {PWM_BITS{1'b1}};

  logic [PWM_BITS-1:0] pwm_cnt;

  // While disabled the count freezes and the LED is driven dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else if (enable) begin
      pwm_cnt <= pwm_cnt + 1'b1;
      pwm_out <= (pwm_cnt < duty);
    end else begin
      pwm_out <= 1'b0;
    end
  end

  assign wrap = enable & (pwm_cnt == CNT_MAX);

endmodule

// File: rtl/led_breather.sv
// Breathing LED driver: ramps PWM duty up, holds, ramps down, holds, on upstream ticks.
module led_breather
  import led_pkg::*;
#(
  parameter int PWM_BITS   = DEF_PWM_BITS,
  parameter int HOLD_STEPS = DEF_HOLD_STEPS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_in,
  input  logic                enable,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] duty,
  output logic [1:0]          phase,
  output logic                period_done
);

  localparam int HW = hold_cnt_width(HOLD_STEPS);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] DUTY_TOP  = DUTY_MAX - 1'b1;
  localparam logic [PWM_BITS-1:0] DUTY_ONE  = {{(PWM_BITS-1){1'b0}}, 1'b1};
  localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_STEPS - 1);

  logic                tick_d;
  logic                pending;
  logic                step;
  logic                wrap;
  logic                apply;
  phase_t              state;
  phase_t              state_next;
  logic [PWM_BITS-1:0] duty_next;
  logic [HW-1:0]       hold_cnt;
  logic [HW-1:0]       hold_next;
  logic                done_next;

  led_pwm_core #(
    .PWM_BITS(PWM_BITS)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .duty   (duty),
    .pwm_out(pwm_out),
    .wrap   (wrap)
  );

  // Steps only land on period boundaries so the duty never changes mid-period.
  assign step  = tick_in & ~tick_d & enable;
  assign apply = wrap & (pending | step);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_d  <= 1'b0;
      pending <= 1'b0;
    end else begin
      tick_d <= tick_in;
      if (!enable || apply) begin
        pending <= 1'b0;
      end else if (step) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= UP;
      duty        <= '0;
      hold_cnt    <= '0;
      period_done <= 1'b0;
    end else begin
      state       <= state_next;
      duty        <= duty_next;
      hold_cnt    <= hold_next;
      period_done <= done_next;
    end
  end

  // Ramp end tests use the old duty, so duty saturates at 0 and MAX without wrapping.
  always_comb begin
    state_next = state;
    duty_next  = duty;
    hold_next  = hold_cnt;
    done_next  = 1'b0;
    if (apply) begin
      case (state)
        UP: begin
          duty_next = duty + 1'b1;
          if (duty == DUTY_TOP) begin
            state_next = HOLD_HI;
            hold_next  = '0;
          end
        end
        HOLD_HI: begin
          if (hold_cnt == HOLD_LAST) begin
            state_next = DOWN;
            hold_next  = '0;
          end else begin
            hold_next = hold_cnt + 1'b1;
          end
        end
        DOWN: begin
          duty_next = duty - 1'b1;
          if (duty == DUTY_ONE) begin
            state_next = HOLD_LO;
            hold_next  = '0;
          end
        end
        HOLD_LO: begin
          if (hold_cnt == HOLD_LAST) begin
            state_next = UP;
            hold_next  = '0;
            done_next  = 1'b1;
          end else begin
            hold_next = hold_cnt + 1'b1;
          end
        end
        default: state_next = UP;
      endcase
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_led_breather.sv
// Directed self-checking bench for led_breather at PWM_BITS=4, HOLD_STEPS=2.
module tb_led_breather;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_in;
  logic       enable;
  logic       pwm_out;
  logic [3:0] duty;
  logic [1:0] phase;
  logic       period_done;

  int checks = 0;
  int passed = 0;
  int pd_count = 0;
  logic [3:0] ref_cnt;

  led_breather #(
    .PWM_BITS  (4),
    .HOLD_STEPS(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_in    (tick_in),
    .enable     (enable),
    .pwm_out    (pwm_out),
    .duty       (duty),
    .phase      (phase),
    .period_done(period_done)
  );

  always #5 clk = ~clk;

  // Reference PWM position: counts enabled cycles since reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ref_cnt <= 4'd0;
    else if (enable) ref_cnt <= ref_cnt + 4'd1;
  end

  always @(posedge clk) begin
    if (period_done) pd_count++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic wait_cnt(input int v);
    for (int i = 0; i < 40; i++) begin
      if (ref_cnt == 4'(v)) return;
      @(negedge clk);
    end
    checks++;
    $display("[TB] FAIL wait_cnt: position %0d not reached, at %0d", v, ref_cnt);
  endtask

  task automatic do_step();
    wait_cnt(3);
    tick_in = 1'b1;
    @(negedge clk);
    tick_in = 1'b0;
    @(negedge clk);
    wait_cnt(0);
  endtask

  function automatic int exp_duty(input int s);
    int p = ((s - 1) % 34) + 1;
    if (p <= 15) return p;
    if (p <= 17) return 15;
    if (p <= 32) return 32 - p;
    return 0;
  endfunction

  function automatic int exp_phase(input int s);
    int p = ((s - 1) % 34) + 1;
    if (p < 15) return 0;
    if (p <= 16) return 1;
    if (p < 32) return 2;
    if (p <= 33) return 3;
    return 0;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; tick_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pwm_out, duty, phase, period_done} !== 8'd0) $display("[TB] FAIL reset_hold: got %b required 0", {pwm_out, duty, phase, period_done});
    else passed++;
    rst_n = 1'b1; enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== 1'b0 || duty !== 4'd0 || phase !== 2'd0) $display("[TB] FAIL reset_idle: pwm=%b duty=%0d phase=%0d required 0/0/0", pwm_out, duty, phase);
      else passed++;
    end
  endtask

  task automatic test_duty5();
    int highs = 0;
    for (int k = 1; k <= 5; k++) begin
      wait_cnt(3);
      tick_in = 1'b1;
      @(negedge clk);
      tick_in = 1'b0;
      wait_cnt(15);
      checks++;
      if (duty !== 4'(k - 1)) $display("[TB] FAIL duty_before_wrap: got %0d required %0d", duty, k - 1);
      else passed++;
      @(negedge clk);
      checks++;
      if (duty !== 4'(k)) $display("[TB] FAIL duty_at_wrap: got %0d required %0d", duty, k);
      else passed++;
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (pwm_out === 1'b1) highs++;
      checks++;
      if (pwm_out !== ((4'(ref_cnt - 4'd1) < 4'd5) ? 1'b1 : 1'b0)) $display("[TB] FAIL pwm_shape: pos=%0d got %b", ref_cnt, pwm_out);
      else passed++;
    end
    checks++;
    if (highs != 5) $display("[TB] FAIL pwm_high_count: got %0d required 5", highs);
    else passed++;
  endtask

  task automatic test_coalesce();
    wait_cnt(2);
    for (int i = 0; i < 3; i++) begin
      tick_in = 1'b1;
      @(negedge clk);
      tick_in = 1'b0;
      @(negedge clk);
    end
    wait_cnt(0);
    checks++;
    if (duty !== 4'd6) $display("[TB] FAIL coalesce: got %0d required 6", duty);
    else passed++;
    @(negedge clk);
    wait_cnt(0);
    checks++;
    if (duty !== 4'd6) $display("[TB] FAIL coalesce_no_leftover: got %0d required 6", duty);
    else passed++;
    wait_cnt(15);
    tick_in = 1'b1;
    @(negedge clk);
    tick_in = 1'b0;
    checks++;
    if (duty !== 4'd7) $display("[TB] FAIL step_at_wrap: got %0d required 7", duty);
    else passed++;
    @(negedge clk);
    wait_cnt(0);
    checks++;
    if (duty !== 4'd7) $display("[TB] FAIL step_at_wrap_once: got %0d required 7", duty);
    else passed++;
  endtask

  task automatic test_enable();
    int exp_pat[16] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    wait_cnt(5);
    checks++;
    if (pwm_out !== 1'b1) $display("[TB] FAIL enable_pre: got %b required 1", pwm_out);
    else passed++;
    enable = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick_in = (i % 4 == 1) ? 1'b1 : 1'b0;
      @(negedge clk);
      checks++;
      if (pwm_out !== 1'b0 || duty !== 4'd7 || phase !== 2'd0) $display("[TB] FAIL frozen: pwm=%b duty=%0d phase=%0d required 0/7/0", pwm_out, duty, phase);
      else passed++;
    end
    tick_in = 1'b0;
    enable = 1'b1;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== 1'(exp_pat[j])) $display("[TB] FAIL resume_pattern[%0d]: got %b required %0d", j, pwm_out, exp_pat[j]);
      else passed++;
    end
    checks++;
    if (duty !== 4'd7) $display("[TB] FAIL resume_duty: got %0d required 7", duty);
    else passed++;
  endtask

  task automatic test_full_cycle_and_async_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pd_count = 0;
    for (int s = 1; s <= 57; s++) begin
      do_step();
      checks++;
      if (duty !== 4'(exp_duty(s)) || phase !== 2'(exp_phase(s))) $display("[TB] FAIL cycle_step%0d: duty=%0d phase=%0d required %0d/%0d", s, duty, phase, exp_duty(s), exp_phase(s));
      else passed++;
      checks++;
      if (period_done !== (s == 34 ? 1'b1 : 1'b0)) $display("[TB] FAIL period_done_step%0d: got %b", s, period_done);
      else passed++;
    end
    checks++;
    if (pd_count != 1) $display("[TB] FAIL period_done_count: got %0d required 1", pd_count);
    else passed++;
    wait_cnt(4);
    checks++;
    if (pwm_out !== 1'b1 || duty !== 4'd9 || phase !== 2'd2) $display("[TB] FAIL pre_reset: pwm=%b duty=%0d phase=%0d required 1/9/2", pwm_out, duty, phase);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pwm_out, duty, phase, period_done} !== 8'd0) $display("[TB] FAIL async_reset: got %b required 0", {pwm_out, duty, phase, period_done});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (pwm_out !== 1'b0 || duty !== 4'd0 || phase !== 2'd0) $display("[TB] FAIL post_reset_idle: pwm=%b duty=%0d phase=%0d", pwm_out, duty, phase);
    else passed++;
    do_step();
    checks++;
    if (duty !== 4'd1 || phase !== 2'd0) $display("[TB] FAIL post_reset_step: duty=%0d phase=%0d required 1/0", duty, phase);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_duty5();
    test_coalesce();
    test_enable();
    test_full_cycle_and_async_reset();
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
